// File: rtl/seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, IR field offsets,
// FSM state encoding and opcode classes.
package seq_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11111;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int C_MSB  = 18;
    localparam int C_LSB  = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_MEM,
        S_DONE,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_MULDIV,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } op_class_e;

    function automatic logic [31:0] sext_c(input logic [18:0] c);
        return {{13{c[18]}}, c};
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier: maps the 5-bit IR opcode onto the sequencing
// class that selects the FSM path.
module seq_decode
    import seq_pkg::*;
(
    input  logic [4:0] op,
    output op_class_e  cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: cls = CLS_RTYPE;
            OP_LDI, OP_ADDI:                        cls = CLS_IMM;
            OP_MUL, OP_DIV:                         cls = CLS_MULDIV;
            OP_BR:                                  cls = CLS_BRANCH;
            OP_LD:                                  cls = CLS_LOAD;
            OP_ST:                                  cls = CLS_STORE;
            default:                                cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving register file, ALU and memory strobes.
// Optional macro ILLEGAL_TRAP_EN: illegal ops and memory timeouts lock the FSM in TRAP.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        conFlag,
    input  logic        memAck,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [4:0]  aluOp,
    output logic        aluFlag,
    output logic [3:0]  rdAddrA,
    output logic [3:0]  rdAddrB,
    output logic        immSel,
    output logic [31:0] immOut,
    output logic        yLatch,
    output logic        zLatch,
    output logic [3:0]  wrAddr,
    output logic        regWrite,
    output logic        wbSel,
    output logic        hiWrite,
    output logic        loWrite,
    output logic        pcLoad,
    output logic        memRead,
    output logic        memWrite
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

`ifdef ILLEGAL_TRAP_EN
    localparam state_e FAULT_STATE = S_TRAP;
`else
    localparam state_e FAULT_STATE = S_DONE;
`endif

    state_e     state;
    state_e     state_next;
    logic [31:0] ir_q;
    logic [7:0] mem_cnt;
    logic       flag_q;
    op_class_e  cls;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic [3:0] port_b;
    logic       imm_operand;
    logic       mem_timeout;

    assign op = ir_q[OP_MSB:OP_LSB];
    assign ra = ir_q[RA_MSB:RA_LSB];
    assign rb = ir_q[RB_MSB:RB_LSB];
    assign rc = ir_q[RC_MSB:RC_LSB];
    assign immOut = sext_c(ir_q[C_MSB:C_LSB]);

    seq_decode u_decode (
        .op  (op),
        .cls (cls)
    );

    // Stores read Ra on port B so the memory data path sees the source register.
    assign port_b      = (cls == CLS_STORE) ? ra : rc;
    assign imm_operand = cls inside {CLS_IMM, CLS_BRANCH, CLS_LOAD, CLS_STORE};
    assign mem_timeout = (state == S_MEM) && !memAck && (mem_cnt == TMO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ir_q    <= '0;
            mem_cnt <= '0;
            flag_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start)
                ir_q <= ir;
            if (state == S_MEM)
                mem_cnt <= mem_cnt + 8'd1;
            else
                mem_cnt <= '0;
            // Captured on the edge into EXEC so aluFlag is stable for the whole EXEC cycle.
            if (state == S_OPERAND)
                flag_q <= conFlag;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign error = (state == S_TRAP);
`else
    logic err_q;

    // Remembers why DONE was entered so error pulses together with done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= ((state == S_DECODE) && (cls == CLS_ILLEGAL)) || mem_timeout;
    end

    assign error = (state == S_DONE) && err_q;
`endif

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        aluOp      = OP_NOP;
        aluFlag    = 1'b0;
        rdAddrA    = 4'd0;
        rdAddrB    = 4'd0;
        immSel     = 1'b0;
        yLatch     = 1'b0;
        zLatch     = 1'b0;
        wrAddr     = 4'd0;
        regWrite   = 1'b0;
        wbSel      = 1'b0;
        hiWrite    = 1'b0;
        loWrite    = 1'b0;
        pcLoad     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                rdAddrA    = rb;
                rdAddrB    = port_b;
                state_next = (cls == CLS_ILLEGAL) ? FAULT_STATE : S_OPERAND;
            end
            S_OPERAND: begin
                rdAddrA    = rb;
                rdAddrB    = port_b;
                yLatch     = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                rdAddrA    = rb;
                rdAddrB    = port_b;
                aluOp      = op;
                immSel     = imm_operand;
                zLatch     = 1'b1;
                aluFlag    = (cls == CLS_BRANCH) && flag_q;
                state_next = (cls == CLS_LOAD || cls == CLS_STORE) ? S_MEM : S_WB_LO;
            end
            S_WB_LO: begin
                state_next = S_DONE;
                case (cls)
                    CLS_MULDIV: begin
                        loWrite    = 1'b1;
                        state_next = S_WB_HI;
                    end
                    CLS_BRANCH: pcLoad = 1'b1;
                    default: begin
                        regWrite = 1'b1;
                        wrAddr   = ra;
                        wbSel    = (cls == CLS_LOAD);
                    end
                endcase
            end
            S_WB_HI: begin
                hiWrite    = 1'b1;
                state_next = S_DONE;
            end
            S_MEM: begin
                rdAddrA  = rb;
                rdAddrB  = port_b;
                memRead  = (cls == CLS_LOAD);
                memWrite = (cls == CLS_STORE);
                if (memAck)
                    state_next = (cls == CLS_LOAD) ? S_WB_LO : S_DONE;
                else if (mem_timeout)
                    state_next = FAULT_STATE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

endmodule
